serial_frame_writer: RTL and testbench
======================================

# serial_frame_writer

Packs the byte stream from the UART receiver into RAM_WIDTH-bit words and writes them sequentially into the frame-buffer RAM. It is the stage directly upstream of the frame-buffer reader that drives the VGA display. It tracks frame boundaries, wraps the address after the last slot, and abandons a stalled frame after an inter-byte timeout.

## Interface
- RAM_WIDTH, 32: word width in bits; must be a multiple of 8.
- RAM_DEPTH, 129600: words per frame, (480*360*24)/32.
- BYTE_TIMEOUT, 1_000_000: idle clk cycles allowed between bytes inside a frame.
- Derived: ADDR_BITS = $clog2(RAM_DEPTH); BYTES_PER_WORD = RAM_WIDTH/8.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_data  in  8  received byte; valid only when rx_ready = 1.
- rx_ready  in  1  one-cycle strobe, one per byte.
- frame_restart  in  1  synchronous soft restart: drop any partial word, set address to 0, go to IDLE.
- we  out  1  RAM write enable; one-cycle pulse per word.
- wr_addr  out  ADDR_BITS  RAM write address.
- wr_data  out  RAM_WIDTH  RAM write word.
- busy  out  1  high while a frame is in progress (state RECEIVE).
- frame_done  out  1  one-cycle pulse, coincident with the we of word RAM_DEPTH-1.
- timeout  out  1  one-cycle pulse when a frame is abandoned on timeout.

## Operation
- FSM states:
  - IDLE: address is 0, byte index is 0, timeout counter is 0.
  - RECEIVE: the frame is being collected.
- Packing is MSB-first. The first byte of a word goes to wr_data[RAM_WIDTH-1 -: 8] and the last byte goes to [7:0].
- The shift register is internal. wr_data changes only on a word write.
- Byte accepted (rx_ready = 1, no rst or frame_restart):
  - The byte shifts into the shift register.
  - The byte index increments.
  - The timeout counter clears.
  - From IDLE, the FSM moves to RECEIVE.
- When the byte index reaches BYTES_PER_WORD:
  - The byte index returns to 0.
  - On the next cycle, we = 1 with wr_addr = current word address and wr_data = packed word.
  - The address then increments.
- Last word (address RAM_DEPTH-1):
  - frame_done pulses together with its we.
  - The address wraps to 0.
  - The FSM returns to IDLE.
- Timeout:
  - In RECEIVE, the counter increments every cycle without rx_ready.
  - When it reaches BYTE_TIMEOUT, timeout pulses for one cycle.
  - The partial word is discarded, the address resets to 0, and the FSM returns to IDLE.
  - No we is issued. Words already written stay in the RAM.
  - The counter does not run in IDLE.
- Priority, highest first: rst, frame_restart, rx_ready, timeout expiry.
  - rx_ready coincident with frame_restart: the byte is dropped.
  - rx_ready coincident with timeout expiry: the byte is accepted and no timeout occurs.
- A byte arriving in the same cycle as a we is accepted as byte 0 of the next word; nothing is lost.
- frame_restart has no effect on wr_data.

## Timing
- Reset values: we = 0, wr_addr = 0, wr_data = 0, busy = 0, frame_done = 0, timeout = 0, state IDLE, all counters 0.
- Latency: the final byte of a word is accepted in cycle N. In cycle N+1, we = 1 with the packed word and the address from before the increment.
- wr_addr updates in cycle N+2. wr_addr is registered and always shows the address of the next write.
- busy rises the cycle after the first byte. It falls in the cycle after frame_done, timeout or frame_restart.
- All outputs are registered; there are no combinational paths from input to output.
- Throughput: the block accepts one byte per cycle if rx_ready is held high on consecutive cycles.
- Reset mid-frame: the partial word is lost, no we is issued, and the next byte starts word 0.

## Structure
- Package frame_buffer_pkg contains:
  - the frame-geometry constants (width 480, height 360, 24 bpp, RAM_WIDTH, RAM_DEPTH);
  - the state enum typedef, shared with the reader.
- Sub-module byte_packer (shift register plus byte index, producing word_valid and word) separates packing from the address/FSM logic.
- The timeout counter stays inline; its width is $clog2(BYTE_TIMEOUT+1).

## Test plan
Bench parameters: RAM_DEPTH = 4, BYTE_TIMEOUT = 16, RAM_WIDTH = 32.
- Reset check: hold rst for 3 cycles → every output is 0 and busy = 0.
- Full frame: send bytes 0x00..0x0F, spaced 3 cycles apart → four we pulses with wr_addr 0..3 and wr_data 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F. frame_done coincides with the 4th we, then busy = 0 and wr_addr = 0.
- Back-to-back bytes: 16 bytes with rx_ready high continuously → same words as the full-frame test; each we arrives 1 cycle after every 4th byte; no byte is dropped.
- Timeout: send 0xAA, 0xBB, then 16 idle cycles → timeout pulses once with no we; the next 4 bytes 0x11..0x14 write 0x11121314 to wr_addr 0.
- Priority: frame_restart asserted in the same cycle as the 3rd byte of word 1 → that byte is dropped and no we is issued; a fresh 4 bytes write to address 0.
- Mid-frame reset: rst after 6 bytes → outputs return to their reset values; a following full frame behaves exactly as in the full-frame test.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// Shared frame-buffer geometry and FSM state encoding for the serial writer
// and the downstream frame-buffer reader.
package frame_buffer_pkg;

  localparam int unsigned FRAME_WIDTH  = 480;
  localparam int unsigned FRAME_HEIGHT = 360;
  localparam int unsigned FRAME_BPP    = 24;
  localparam int unsigned FB_RAM_WIDTH = 32;
  localparam int unsigned FB_RAM_DEPTH = (FRAME_WIDTH * FRAME_HEIGHT * FRAME_BPP) / FB_RAM_WIDTH;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } fb_state_e;

endpackage

// File: rtl/byte_packer.sv
// MSB-first byte-to-word packer: shifts bytes in and emits a registered
// word_valid pulse with the completed word the cycle after its last byte.
module byte_packer #(
  parameter int unsigned RAM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 word_last,
  output logic                 word_valid,
  output logic [RAM_WIDTH-1:0] word
);

  localparam int unsigned BYTES_PER_WORD = RAM_WIDTH / 8;
  localparam int unsigned IDX_BITS = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [RAM_WIDTH-1:0] shift_q;
  logic [RAM_WIDTH-1:0] shift_next;
  logic [IDX_BITS-1:0]  idx_q;

  assign word_last = (idx_q == IDX_BITS'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_next = (shift_q << 8) | RAM_WIDTH'(byte_data);
  end

  // Stale shift contents after a clear are harmless: a full word of shifts
  // overwrites every byte before the next word is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      idx_q      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx_q <= '0;
      end else if (byte_valid) begin
        shift_q <= shift_next;
        if (word_last) begin
          idx_q      <= '0;
          word_valid <= 1'b1;
          word       <= shift_next;
        end else begin
          idx_q <= idx_q + IDX_BITS'(1);
        end
      end
    end
  end

endmodule

// File: rtl/serial_frame_writer.sv
// Packs the UART byte stream into RAM words and writes a frame sequentially,
// with address wrap at end of frame and inter-byte timeout abandonment.
module serial_frame_writer
  import frame_buffer_pkg::*;
#(
  parameter int unsigned RAM_WIDTH    = FB_RAM_WIDTH,
  parameter int unsigned RAM_DEPTH    = FB_RAM_DEPTH,
  parameter int unsigned BYTE_TIMEOUT = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_ready,
  input  logic                         frame_restart,
  output logic                         we,
  output logic [$clog2(RAM_DEPTH)-1:0] wr_addr,
  output logic [RAM_WIDTH-1:0]         wr_data,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         timeout
);

  localparam int unsigned ADDR_BITS = $clog2(RAM_DEPTH);
  localparam int unsigned TO_BITS   = $clog2(BYTE_TIMEOUT + 1);

  fb_state_e            state_q, state_d;
  logic [ADDR_BITS-1:0] word_addr_q;
  logic [TO_BITS-1:0]   idle_cnt_q;
  logic                 accept;
  logic                 word_last;
  logic                 end_pulse;
  logic                 expire;
  logic                 clear;
  logic                 last_slot;

  assign accept    = rx_ready && !frame_restart;
  assign end_pulse = frame_done || timeout;
  assign last_slot = (word_addr_q == ADDR_BITS'(RAM_DEPTH - 1));
  assign expire    = (state_q == RECEIVE) && !end_pulse && !rx_ready && !frame_restart &&
                     (idle_cnt_q == TO_BITS'(BYTE_TIMEOUT - 1));
  assign clear     = frame_restart || expire;
  assign busy      = (state_q == RECEIVE);

  byte_packer #(
    .RAM_WIDTH (RAM_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .byte_valid (accept),
    .byte_data  (rx_data),
    .word_last  (word_last),
    .word_valid (we),
    .word       (wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The frame ends one cycle after frame_done/timeout so busy drops in the
  // cycle following the pulse; a byte in that cycle starts the next frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RECEIVE;
      RECEIVE: begin
        if (frame_restart)  state_d = IDLE;
        else if (end_pulse) state_d = accept ? RECEIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // word_addr_q tracks the slot of the word being assembled; wr_addr trails
  // it by one cycle so it still holds the old address while we is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_addr_q <= '0;
      wr_addr     <= '0;
      idle_cnt_q  <= '0;
      frame_done  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      frame_done <= accept && word_last && last_slot;
      timeout    <= expire;
      if (clear) begin
        word_addr_q <= '0;
        wr_addr     <= '0;
      end else begin
        wr_addr <= word_addr_q;
        if (accept && word_last)
          word_addr_q <= last_slot ? '0 : word_addr_q + ADDR_BITS'(1);
      end
      if (clear || accept)
        idle_cnt_q <= '0;
      else if (state_q == RECEIVE && !end_pulse)
        idle_cnt_q <= idle_cnt_q + TO_BITS'(1);
      else
        idle_cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_serial_frame_writer.sv
// Directed, table-driven bench for serial_frame_writer with a small frame
// (4 words of 32 bits) and a 16-cycle byte timeout.
module tb_serial_frame_writer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 16;
  localparam int unsigned W     = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_ready;
  logic         frame_restart;
  logic         we;
  logic [1:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         busy;
  logic         frame_done;
  logic         timeout;

  serial_frame_writer #(
    .RAM_WIDTH    (W),
    .RAM_DEPTH    (DEPTH),
    .BYTE_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .frame_restart (frame_restart),
    .we            (we),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .frame_done    (frame_done),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    logic        done;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    logic        done;
  } exp_t;

  typedef struct {
    string name;
    int    gap;
  } scen_t;

  int   cyc = 0;
  wr_t  writes[$];
  int   acc_cyc[$];
  int   to_count = 0;
  int   to_cyc = -1;
  int   glitch = 0;
  int   fd_orphan = 0;
  int   busy_after_fd = 0;
  logic prev_fd = 1'b0;
  logic prev_rst = 1'b1;
  logic [W-1:0] prev_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) writes.push_back('{addr: wr_addr, data: wr_data, done: frame_done, cyc: cyc});
    if (frame_done && !we) fd_orphan++;
    if (timeout) begin
      to_count++;
      to_cyc = cyc;
    end
    if (!we && !prev_rst && wr_data != prev_data) glitch++;
    if (prev_fd && busy) busy_after_fd++;
    prev_fd   = frame_done;
    prev_rst  = rst;
    prev_data = wr_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_ready = 1'b1;
    acc_cyc.push_back(cyc);
    tick();
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    repeat (gap) tick();
  endtask

  task automatic restart();
    frame_restart = 1'b1;
    tick();
    frame_restart = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " we"},         64'(we), 64'd0);
    check({tag, " wr_addr"},    64'(wr_addr), 64'd0);
    check({tag, " wr_data"},    64'(wr_data), 64'd0);
    check({tag, " busy"},       64'(busy), 64'd0);
    check({tag, " frame_done"}, 64'(frame_done), 64'd0);
    check({tag, " timeout"},    64'(timeout), 64'd0);
  endtask

  exp_t exp_frame[4];

  task automatic run_frame(input string tag, input int gap);
    writes.delete();
    acc_cyc.delete();
    busy_after_fd = 0;
    for (int i = 0; i < 16; i++) send_byte(8'(i), gap);
    repeat (4) tick();
    check({tag, " write count"}, 64'(writes.size()), 64'd4);
    for (int i = 0; i < 4 && i < writes.size(); i++) begin
      check($sformatf("%s w%0d addr", tag, i), 64'(writes[i].addr), 64'(exp_frame[i].addr));
      check($sformatf("%s w%0d data", tag, i), 64'(writes[i].data), 64'(exp_frame[i].data));
      check($sformatf("%s w%0d done", tag, i), 64'(writes[i].done), 64'(exp_frame[i].done));
      check($sformatf("%s w%0d latency", tag, i), 64'(writes[i].cyc), 64'(acc_cyc[4*i+3] + 1));
    end
    check({tag, " busy after frame"},    64'(busy), 64'd0);
    check({tag, " wr_addr after frame"}, 64'(wr_addr), 64'd0);
    check({tag, " busy after done"},     64'(busy_after_fd), 64'd0);
  endtask

  scen_t scen[2];

  initial begin
    int to0;

    exp_frame[0] = '{addr: 2'd0, data: 32'h00010203, done: 1'b0};
    exp_frame[1] = '{addr: 2'd1, data: 32'h04050607, done: 1'b0};
    exp_frame[2] = '{addr: 2'd2, data: 32'h08090A0B, done: 1'b0};
    exp_frame[3] = '{addr: 2'd3, data: 32'h0C0D0E0F, done: 1'b1};
    scen[0] = '{name: "spaced", gap: 2};
    scen[1] = '{name: "b2b",    gap: 0};

    rst = 1'b1;
    rx_ready = 1'b0;
    rx_data = 8'h00;
    frame_restart = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    foreach (scen[s]) run_frame(scen[s].name, scen[s].gap);

    // Timeout: two bytes then an idle stretch past the limit.
    writes.delete();
    acc_cyc.delete();
    to0 = to_count;
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 18);
    check("timeout count", 64'(to_count - to0), 64'd1);
    check("timeout cycle", 64'(to_cyc), 64'(acc_cyc[1] + 17));
    check("timeout no we", 64'(writes.size()), 64'd0);
    check("timeout busy",  64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 0);
    repeat (2) tick();
    check("post-timeout count", 64'(writes.size()), 64'd1);
    if (writes.size() > 0) begin
      check("post-timeout addr", 64'(writes[0].addr), 64'd0);
      check("post-timeout data", 64'(writes[0].data), 64'h11121314);
    end
    check("post-timeout busy", 64'(busy), 64'd1);
    restart();
    check("restart busy",    64'(busy), 64'd0);
    check("restart wr_addr", 64'(wr_addr), 64'd0);

    // Byte arriving on the last allowed idle cycle is accepted.
    writes.delete();
    to0 = to_count;
    for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 15);
    check("edge no timeout", 64'(to_count - to0), 64'd0);
    check("edge count", 64'(writes.size()), 64'd1);
    if (writes.size() > 0) check("edge data", 64'(writes[0].data), 64'h21222324);
    restart();

    // frame_restart coincident with the 3rd byte of word 1.
    writes.delete();
    for (int i = 0; i < 4; i++) send_byte(8'h01 + 8'(i), 1);
    send_byte(8'h05, 1);
    send_byte(8'h06, 1);
    rx_data = 8'h07;
    rx_ready = 1'b1;
    frame_restart = 1'b1;
    tick();
    rx_ready = 1'b0;
    frame_restart = 1'b0;
    check("prio busy",    64'(busy), 64'd0);
    check("prio wr_addr", 64'(wr_addr), 64'd0);
    tick();
    check("prio count", 64'(writes.size()), 64'd1);
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1);
    tick();
    check("prio count2", 64'(writes.size()), 64'd2);
    if (writes.size() > 1) begin
      check("prio addr", 64'(writes[1].addr), 64'd0);
      check("prio data", 64'(writes[1].data), 64'hA0A1A2A3);
    end
    restart();

    // Mid-frame reset after 6 bytes.
    writes.delete();
    for (int i = 0; i < 6; i++) send_byte(8'h40 + 8'(i), 0);
    rst = 1'b1;
    tick();
    check_reset("midreset");
    rst = 1'b0;
    tick();
    run_frame("after-reset", 2);

    check("wr_data only on we", 64'(glitch), 64'd0);
    check("frame_done without we", 64'(fd_orphan), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
